cvxif_wb_buffer: RTL and testbench



---
 rtl/cvxif_wb_buffer.sv | 179 +++++++++++++++++
 tb/tb_cvxif_wb_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_wb_buffer.sv
// Writeback buffer for the CV-X-IF coprocessor. An in-order result FIFO feeds the
// scoreboard, and an in-flight counter throttles further offload.

module cvxif_wb_buffer_chk #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             issue_fire_i,
    input  logic             pop_i,
    input  logic [CNT_W-1:0] cnt_i
);
    // Saturation of the in-flight counter means the issue/writeback protocol was broken.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(!clear_i && issue_fire_i && !pop_i && (cnt_i == CNT_W'(MAX_OUTSTANDING))));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(!clear_i && pop_i && !issue_fire_i && (cnt_i == {CNT_W{1'b0}})));
endmodule

module cvxif_wb_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   issue_fire_i,
    output logic                                   issue_allow_o,
    input  logic                                   res_valid_i,
    output logic                                   res_ready_o,
    input  logic [TRANS_ID_BITS-1:0]               res_id_i,
    input  logic [XLEN-1:0]                        res_data_i,
    input  logic                                   res_we_i,
    input  logic                                   res_exc_i,
    input  logic [5:0]                             res_exccode_i,
    output logic                                   wb_valid_o,
    input  logic                                   wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]               wb_trans_id_o,
    output logic [XLEN-1:0]                        wb_result_o,
    output logic                                   wb_we_o,
    output logic                                   wb_ex_valid_o,
    output logic [XLEN-1:0]                        wb_ex_cause_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PW-1:0]    PTR_ONE  = PW'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          data;
        logic                     we;
        logic                     exc;
        logic [5:0]               exccode;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head_s;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            full_s, empty_s, push_s, pop_s;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign push_s  = res_valid_i & ~full_s;
    assign pop_s   = ~empty_s & wb_ready_i;
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

    assign res_ready_o   = ~full_s;
    assign issue_allow_o = (cnt_q < CNT_MAX);
    assign outstanding_o = cnt_q;

    // Next-state for pointers and the in-flight counter; flush overrides all traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            cnt_d    = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({issue_fire_i, pop_s})
                2'b10: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                2'b01: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage. It needs no reset because the outputs are gated by the empty flag.
    always_ff @(posedge clk_i) begin
        if (push_s && !clear_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{id: res_id_i, data: res_data_i, we: res_we_i,
                                         exc: res_exc_i, exccode: res_exccode_i};
        end
    end

    // Head decode. An exception entry suppresses its register write and data.
    always_comb begin
        wb_valid_o    = 1'b0;
        wb_trans_id_o = {TRANS_ID_BITS{1'b0}};
        wb_result_o   = {XLEN{1'b0}};
        wb_we_o       = 1'b0;
        wb_ex_valid_o = 1'b0;
        wb_ex_cause_o = {XLEN{1'b0}};
        if (!empty_s) begin
            wb_valid_o    = 1'b1;
            wb_trans_id_o = head_s.id;
            if (head_s.exc) begin
                wb_ex_valid_o = 1'b1;
                wb_ex_cause_o = {{(XLEN-6){1'b0}}, head_s.exccode};
            end else begin
                wb_result_o = head_s.data;
                wb_we_o     = head_s.we;
            end
        end else begin
            wb_valid_o = 1'b0;
        end
    end

    cvxif_wb_buffer_chk #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .issue_fire_i(issue_fire_i),
        .pop_i       (pop_s),
        .cnt_i       (cnt_q)
    );
endmodule

// File: tb/tb_cvxif_wb_buffer.sv
// Bench for cvxif_wb_buffer. A queue-and-counter reference model predicts every output,
// and scenario tasks compare the DUT against it and against fixed values.

module tb_cvxif_wb_buffer;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int TID   = 3;
    localparam int MAXO  = 4;
    localparam int CW    = $clog2(MAXO + 1);
    localparam int BW    = 3 + CW + TID + XLEN + 2 + XLEN;

    logic            clk = 1'b0;
    logic            rst_ni, clear, issue_fire, res_valid, res_we, res_exc, wb_ready;
    logic [TID-1:0]  res_id;
    logic [XLEN-1:0] res_data;
    logic [5:0]      res_exccode;
    logic            issue_allow, res_ready, wb_valid, wb_we, wb_ex_valid;
    logic [TID-1:0]  wb_trans_id;
    logic [XLEN-1:0] wb_result, wb_ex_cause;
    logic [CW-1:0]   outstanding;

    typedef struct {
        logic [TID-1:0]  id;
        logic [XLEN-1:0] data;
        logic            we;
        logic            exc;
        logic [5:0]      code;
    } ent_t;

    ent_t mq[$];
    int   mcnt = 0;
    int   cmp  = 0;
    int   errs = 0;

    cvxif_wb_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(TID), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .issue_fire_i(issue_fire),
        .issue_allow_o(issue_allow), .res_valid_i(res_valid), .res_ready_o(res_ready),
        .res_id_i(res_id), .res_data_i(res_data), .res_we_i(res_we), .res_exc_i(res_exc),
        .res_exccode_i(res_exccode), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_trans_id_o(wb_trans_id), .wb_result_o(wb_result), .wb_we_o(wb_we),
        .wb_ex_valid_o(wb_ex_valid), .wb_ex_cause_o(wb_ex_cause), .outstanding_o(outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [BW-1:0] obs_bundle();
        return {wb_valid, res_ready, issue_allow, outstanding, wb_trans_id, wb_result,
                wb_we, wb_ex_valid, wb_ex_cause};
    endfunction

    function automatic logic [BW-1:0] exp_bundle();
        logic v, we, exv;
        logic [TID-1:0] id;
        logic [XLEN-1:0] res, cause;
        v = 1'b0; we = 1'b0; exv = 1'b0; id = '0; res = '0; cause = '0;
        if (mq.size() > 0) begin
            v  = 1'b1;
            id = mq[0].id;
            if (mq[0].exc) begin
                exv   = 1'b1;
                cause = XLEN'(mq[0].code);
            end else begin
                res = mq[0].data;
                we  = mq[0].we;
            end
        end
        return {v, (mq.size() < DEPTH), (mcnt < MAXO), CW'(mcnt), id, res, we, exv, cause};
    endfunction

    // Advance the model by one clock using the current inputs, then move to the next falling edge.
    task automatic step();
        bit full, do_pop;
        full   = (mq.size() >= DEPTH);
        do_pop = (mq.size() > 0) && wb_ready;
        if (clear) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (do_pop) mq.delete(0);
            if (res_valid && !full) mq.push_back('{res_id, res_data, res_we, res_exc, res_exccode});
            if (issue_fire && !do_pop && mcnt < MAXO) mcnt++;
            else if (!issue_fire && do_pop && mcnt > 0) mcnt--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clear = 1'b0; issue_fire = 1'b0; res_valid = 1'b0; res_we = 1'b0; res_exc = 1'b0;
        wb_ready = 1'b0; res_id = '0; res_data = '0; res_exccode = '0;
    endtask

    task automatic offer(input int id, input logic [XLEN-1:0] d, input logic we, input logic exc,
                         input logic [5:0] code);
        res_valid = 1'b1; res_id = TID'(id); res_data = d; res_we = we; res_exc = exc; res_exccode = code;
    endtask

    task automatic test_reset();
        cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL reset_state: got %h want %h", obs_bundle(), exp_bundle()); end
        cmp++; if ({wb_valid, res_ready, issue_allow, outstanding, wb_result} !== {1'b1 == 1'b0, 1'b1, 1'b1, CW'(0), 64'h0}) begin
            errs++; $display("FAIL reset_const: got %b%b%b %0d %h want 0110 0", wb_valid, res_ready, issue_allow, outstanding, wb_result); end
    endtask

    task automatic test_single();
        issue_fire = 1'b1; step(); issue_fire = 1'b0;
        cmp++; if (outstanding !== CW'(1)) begin errs++; $display("FAIL single_cnt: got %0d want 1", outstanding); end
        offer(2, 64'hDEAD, 1'b1, 1'b0, 6'd0);
        cmp++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL single_fallthrough: got %b want 0", wb_valid); end
        step(); res_valid = 1'b0;
        cmp++; if ({wb_valid, wb_trans_id, wb_result, wb_we, wb_ex_valid, issue_allow} !== {1'b1, 3'd2, 64'hDEAD, 1'b1, 1'b0, 1'b1}) begin
            errs++; $display("FAIL single_head: got %b %0d %h %b %b %b want 1 2 dead 1 0 1", wb_valid, wb_trans_id, wb_result, wb_we, wb_ex_valid, issue_allow); end
        cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL single_model: got %h want %h", obs_bundle(), exp_bundle()); end
        wb_ready = 1'b1; step(); wb_ready = 1'b0;
        cmp++; if ({wb_valid, outstanding, issue_allow} !== {1'b0, CW'(0), 1'b1}) begin
            errs++; $display("FAIL single_pop: got %b %0d %b want 0 0 1", wb_valid, outstanding, issue_allow); end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] d[5];
        for (int i = 0; i < 4; i++) begin
            issue_fire = 1'b1; step();
            cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL bp_issue%0d: got %h want %h", i, obs_bundle(), exp_bundle()); end
        end
        issue_fire = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d[i] = {$urandom, $urandom};
            offer(i, d[i], 1'b1, 1'b0, 6'd0);
            cmp++; if (res_ready !== (i < 4)) begin errs++; $display("FAIL bp_ready%0d: got %b want %b", i, res_ready, (i < 4)); end
            step();
            cmp++; if ({wb_trans_id, wb_result} !== {3'd0, d[0]}) begin
                errs++; $display("FAIL bp_hold%0d: got %0d %h want 0 %h", i, wb_trans_id, wb_result, d[0]); end
        end
        res_valid = 1'b0; wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmp++; if ({wb_valid, wb_trans_id, wb_result} !== {1'b1, TID'(k), d[k]}) begin
                errs++; $display("FAIL bp_drain%0d: got %b %0d %h want 1 %0d %h", k, wb_valid, wb_trans_id, wb_result, k, d[k]); end
            step();
            if (k == 0) begin
                cmp++; if (res_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_back: got %b want 1", res_ready); end
            end
        end
        wb_ready = 1'b0;
        cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL bp_end: got %h want %h", obs_bundle(), exp_bundle()); end
    endtask

    task automatic test_exception();
        issue_fire = 1'b1; step(); issue_fire = 1'b0;
        offer(5, 64'h55, 1'b1, 1'b1, 6'd2); step(); res_valid = 1'b0;
        cmp++; if ({wb_valid, wb_ex_valid, wb_ex_cause, wb_we, wb_result} !== {1'b1, 1'b1, 64'd2, 1'b0, 64'd0}) begin
            errs++; $display("FAIL exc_head: got %b %b %h %b %h want 1 1 2 0 0", wb_valid, wb_ex_valid, wb_ex_cause, wb_we, wb_result); end
        cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL exc_model: got %h want %h", obs_bundle(), exp_bundle()); end
        wb_ready = 1'b1; step(); wb_ready = 1'b0;
        cmp++; if ({wb_ex_valid, wb_ex_cause, outstanding} !== {1'b0, 64'd0, CW'(0)}) begin
            errs++; $display("FAIL exc_after: got %b %h %0d want 0 0 0", wb_ex_valid, wb_ex_cause, outstanding); end
    endtask

    task automatic test_limit();
        issue_fire = 1'b1;
        repeat (4) step();
        issue_fire = 1'b0;
        cmp++; if ({issue_allow, outstanding} !== {1'b0, CW'(4)}) begin
            errs++; $display("FAIL lim_full: got %b %0d want 0 4", issue_allow, outstanding); end
        for (int i = 0; i < 2; i++) begin
            offer(i, {$urandom, $urandom}, 1'b1, 1'b0, 6'd0); step();
        end
        res_valid = 1'b0;
        issue_fire = 1'b1; wb_ready = 1'b1; step(); issue_fire = 1'b0;
        cmp++; if ({outstanding, issue_allow} !== {CW'(4), 1'b0}) begin
            errs++; $display("FAIL lim_both: got %0d %b want 4 0", outstanding, issue_allow); end
        step(); wb_ready = 1'b0;
        cmp++; if ({outstanding, issue_allow} !== {CW'(3), 1'b1}) begin
            errs++; $display("FAIL lim_pop: got %0d %b want 3 1", outstanding, issue_allow); end
        cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL lim_model: got %h want %h", obs_bundle(), exp_bundle()); end
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic test_wrap();
        localparam int N = 3 * DEPTH + 1;
        logic [XLEN-1:0] wd[N];
        int issued = 0, pushed = 0, popped = 0, cyc = 0;
        for (int i = 0; i < N; i++) wd[i] = {$urandom, $urandom};
        while (popped < N && cyc < 600) begin
            wb_ready   = 1'($urandom_range(0, 1));
            issue_fire = (issued < N) && (mcnt < MAXO) && ($urandom_range(0, 1) == 1);
            if (pushed < issued && $urandom_range(0, 2) != 0) offer(pushed, wd[pushed], 1'b1, 1'b0, 6'd0);
            else res_valid = 1'b0;
            cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL wrap_c%0d: got %h want %h", cyc, obs_bundle(), exp_bundle()); end
            if (mq.size() > 0 && wb_ready) begin
                cmp++; if ({wb_valid, wb_trans_id, wb_result} !== {1'b1, TID'(popped), wd[popped]}) begin
                    errs++; $display("FAIL wrap_pop%0d: got %b %0d %h want 1 %0d %h", popped, wb_valid, wb_trans_id, wb_result, popped % 8, wd[popped]); end
                popped++;
            end
            if (res_valid && mq.size() < DEPTH) pushed++;
            if (issue_fire) issued++;
            step();
            cyc++;
        end
        idle_inputs();
        cmp++; if (popped != N) begin errs++; $display("FAIL wrap_budget: got %0d want %0d delivered", popped, N); end
    endtask

    task automatic test_flush();
        issue_fire = 1'b1; repeat (3) step(); issue_fire = 1'b0;
        for (int i = 0; i < 3; i++) begin offer(i, {$urandom, $urandom}, 1'b1, 1'b0, 6'd0); step(); end
        cmp++; if ({wb_valid, outstanding} !== {1'b1, CW'(3)}) begin
            errs++; $display("FAIL flush_pre: got %b %0d want 1 3", wb_valid, outstanding); end
        clear = 1'b1; offer(7, 64'hBAD, 1'b1, 1'b0, 6'd0); step(); clear = 1'b0; res_valid = 1'b0;
        cmp++; if ({wb_valid, outstanding, res_ready, issue_allow} !== {1'b0, CW'(0), 1'b1, 1'b1}) begin
            errs++; $display("FAIL flush_state: got %b %0d %b %b want 0 0 1 1", wb_valid, outstanding, res_ready, issue_allow); end
        wb_ready = 1'b1; step(); wb_ready = 1'b0;
        cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL flush_dropped: got %h want %h", obs_bundle(), exp_bundle()); end
    endtask

    task automatic test_reset_mid();
        issue_fire = 1'b1; repeat (3) step(); issue_fire = 1'b0;
        for (int i = 0; i < 3; i++) begin offer(i, {$urandom, $urandom}, 1'b1, 1'b0, 6'd0); step(); end
        res_valid = 1'b0; wb_ready = 1'b1; step();
        #2 rst_ni = 1'b0;
        mq.delete(); mcnt = 0;
        #1;
        cmp++; if ({wb_valid, outstanding, res_ready, issue_allow, wb_result} !== {1'b0, CW'(0), 1'b1, 1'b1, 64'd0}) begin
            errs++; $display("FAIL rst_async: got %b %0d %b %b %h want 0 0 1 1 0", wb_valid, outstanding, res_ready, issue_allow, wb_result); end
        @(negedge clk); wb_ready = 1'b0; rst_ni = 1'b1;
        step();
        cmp++; if (obs_bundle() !== exp_bundle()) begin errs++; $display("FAIL rst_after: got %h want %h", obs_bundle(), exp_bundle()); end
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_exception();
        test_limit();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
